nunchuck_responder: RTL and testbench
=====================================

Name: nunchuck_responder

Overview:
- I2C target (slave) emulating a Wii Nunchuck at 7-bit address 0x52.
- Answers the existing nunchuck I2C master: accepts init writes and register-pointer writes, then serves the 6-byte controller report.
- Used as the bench/loopback partner for the game's nunchuck driver. Report contents come from ports, so testbenches and demo logic can inject stick, accelerometer and button values.

Parameters:
- DEV_ADDR, 7'h52, 7-bit target address matched.
- SYNC_STAGES, 2, flops in each SCL/SDA input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 20x the SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  I2C clock from the master; this block never stretches it.
- sda  inout  1  I2C data, open-drain: driven 0 or Z only.
- stick_x  input  8  joystick X.
- stick_y  input  8  joystick Y.
- accel_x  input  10  accelerometer X.
- accel_y  input  10  accelerometer Y.
- accel_z  input  10  accelerometer Z.
- z  input  1  Z button, 1 = pressed.
- c  input  1  C button, 1 = pressed.
- init_done  output  1  set once 0x55 has been written to register 0xF0.
- reg_ptr  output  8  current register pointer.
- txn_done  output  1  one-clk pulse on STOP that ends an addressed transaction.

Behaviour:
- Reset (asynchronous):
  - sda released (Z); state IDLE; init_done=0; reg_ptr=0x00; txn_done=0.
  - Snapshot registers cleared to 0; synchronizers set to 1.
- Input path:
  - scl and sda pass through SYNC_STAGES flops, then one edge-detect flop.
  - The sda drive responds 3 clk (SYNC_STAGES+1) after an SCL falling edge.
- Bus conditions (evaluated on synchronized signals):
  - START: SDA falls while SCL=1. From any state, go to ADDR and clear the bit counter.
  - STOP: SDA rises while SCL=1. From any state, go to IDLE and release sda.
  - txn_done pulses if the address had matched since the last START.
- Bit timing:
  - Receive bits are sampled on SCL rising edge, MSB first.
  - sda drive changes only after SCL falling edge, never while SCL=1.
- States:
  - IDLE: sda released; wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - If address == DEV_ADDR, go to ADDR_ACK.
    - Otherwise go to IDLE, never driving sda.
  - ADDR_ACK: drive 0 from SCL fall after bit 8 until SCL fall after bit 9.
    - If R/W=0, go to WR_BYTE and mark the next byte as the pointer byte.
    - If R/W=1, latch the snapshot at entry to ADDR_ACK, then go to RD_BYTE.
  - WR_BYTE: shift 8 bits, then go to WR_ACK. Every written byte is ACKed.
  - WR_ACK:
    - First byte after the address: load reg_ptr.
    - Later bytes: if reg_ptr==0xF0 and data==0x55, set init_done. Data written to any other register is ignored.
    - After each data byte, reg_ptr increments (mod 256).
  - RD_BYTE:
    - Drive the MSB of the read byte after the ACK-phase SCL fall.
    - For each bit, drive 0 for a 0 bit and Z for a 1 bit.
    - Shift on each SCL fall.
    - reg_ptr increments (mod 256) after bit 8.
  - RD_ACK: release sda and sample the master's bit on SCL rise.
    - 0 (ACK): go to RD_BYTE with the next byte.
    - 1 (NACK): go to IDLE, keep sda released, wait for STOP or START.
- Read data mux:
  - If init_done=0: 0xFF.
  - Else if reg_ptr < 6: report byte reg_ptr. Else 0xFF.
- Report bytes (from snapshot):
  - B0 = stick_x
  - B1 = stick_y
  - B2 = accel_x[9:2]
  - B3 = accel_y[9:2]
  - B4 = accel_z[9:2]
  - B5 = {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c, ~z} (buttons active-low on the wire).
- Snapshot: input changes during a read burst do not affect bytes already latched.
- Boundaries:
  - Repeated START mid-byte aborts that byte. A partial pointer/data byte is discarded and reg_ptr is unchanged.
  - A STOP immediately after the address ACK (zero data bytes) is legal.
  - reg_ptr wraps 0xFF->0x00.
  - A general-call address (0x00) is not ACKed.

Test Plan:
- Write sequence 0xA4, 0xF0, 0x55, STOP -> three ACKs; init_done=1 after byte 3 ACK; txn_done pulses once; reg_ptr=0xF1.
- Before init: write 0xA4, 0x00; read 0xA5 for 6 bytes -> all 0xFF; reg_ptr ends at 0x06.
- After init: stick_x=0x80, stick_y=0x7F, accel_x=0x201, accel_y=0x1FE, accel_z=0x3FF, z=1, c=0. Write 0xA4, 0x00; read 6 bytes -> 80 7F 80 7F FF E6. Change inputs mid-burst -> bytes unchanged.
- Address 0xA6 (0x53) -> no ACK; sda stays Z for the whole frame; txn_done never pulses.
- Read from pointer 0x04: master ACKs byte 0 and NACKs byte 1 -> bytes FF E6 when z=1, c=0; sda released in the RD_ACK slot and stays released until STOP; reg_ptr=0x06.
- Assert rst while RD_BYTE is driving 0 -> sda Z in the same cycle; init_done=0; reg_ptr=0x00. After reset, the next frame 0xA4 gets ACKed.

Source files
------------

// File: rtl/nunchuck_responder.sv
// ---------------------------------------------------------------------------
// nunchuck_responder
//
// I2C target that emulates a Wii Nunchuck so the game's nunchuck driver can
// be exercised against a live bus partner. It accepts init writes and
// register-pointer writes, then serves the 6-byte controller report. The
// report is built from a snapshot of the stick/accelerometer/button ports,
// which is taken when a read address is acknowledged.
//
// Ports:
//   clk        system clock, at least 20x the SCL frequency
//   rst        asynchronous active-high reset
//   scl        I2C clock from the master (never stretched here)
//   sda        I2C data, open-drain (driven 0 or released)
//   stick_x/y  8-bit joystick position
//   accel_x/y/z 10-bit accelerometer readings
//   z, c       buttons, 1 = pressed (sent active-low on the wire)
//   init_done  set once 0x55 has been written to register 0xF0
//   reg_ptr    current register pointer
//   txn_done   one-clk pulse on the STOP that ends an addressed transaction
// ---------------------------------------------------------------------------
module nunchuck_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h52,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] stick_x,
  input  logic [7:0] stick_y,
  input  logic [9:0] accel_x,
  input  logic [9:0] accel_y,
  input  logic [9:0] accel_z,
  input  logic       z,
  input  logic       c,
  output logic       init_done,
  output logic [7:0] reg_ptr,
  output logic       txn_done
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK
  } state_t;

  // Input synchronizers plus one edge-detect flop per line
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall;
  logic start_cond, stop_cond;

  // Protocol state
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       first_byte_q, first_byte_d;
  logic       addr_match_q, addr_match_d;
  logic       sda_oe_q, sda_oe_d;
  logic       init_done_q, init_done_d;
  logic [7:0] reg_ptr_q, reg_ptr_d;
  logic       txn_done_q, txn_done_d;

  // Report snapshot
  logic [7:0] snap_sx_q, snap_sx_d;
  logic [7:0] snap_sy_q, snap_sy_d;
  logic [9:0] snap_ax_q, snap_ax_d;
  logic [9:0] snap_ay_q, snap_ay_d;
  logic [9:0] snap_az_q, snap_az_d;
  logic       snap_z_q, snap_z_d;
  logic       snap_c_q, snap_c_d;

  logic [7:0] rd_data;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  // SDA edges only count as bus conditions while SCL is steady high
  assign start_cond = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_cond  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  // Read mux: unreported registers and the pre-init state read as 0xFF
  always_comb begin
    rd_data = 8'hFF;
    if (init_done_q) begin
      case (reg_ptr_q)
        8'd0:    rd_data = snap_sx_q;
        8'd1:    rd_data = snap_sy_q;
        8'd2:    rd_data = snap_ax_q[9:2];
        8'd3:    rd_data = snap_ay_q[9:2];
        8'd4:    rd_data = snap_az_q[9:2];
        8'd5:    rd_data = {snap_az_q[1:0], snap_ay_q[1:0], snap_ax_q[1:0],
                            ~snap_c_q, ~snap_z_q};
        default: rd_data = 8'hFF;
      endcase
    end
  end

  // Next-state logic. STOP and START override whatever the FSM is doing.
  // The sda drive is registered so it always lags the synchronized SCL fall
  // by one clock and never changes while SCL is high.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    first_byte_d = first_byte_q;
    addr_match_d = addr_match_q;
    sda_oe_d     = sda_oe_q;
    init_done_d  = init_done_q;
    reg_ptr_d    = reg_ptr_q;
    txn_done_d   = 1'b0;
    snap_sx_d    = snap_sx_q;
    snap_sy_d    = snap_sy_q;
    snap_ax_d    = snap_ax_q;
    snap_ay_d    = snap_ay_q;
    snap_az_d    = snap_az_q;
    snap_z_d     = snap_z_q;
    snap_c_d     = snap_c_q;

    if (stop_cond) begin
      state_d      = IDLE;
      sda_oe_d     = 1'b0;
      txn_done_d   = addr_match_q;
      addr_match_d = 1'b0;
    end else if (start_cond) begin
      state_d      = ADDR;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end

        ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            // General call is never acknowledged
            if (shift_q[7:1] == DEV_ADDR && shift_q[7:1] != 7'h00) begin
              state_d      = ADDR_ACK;
              sda_oe_d     = 1'b1;
              rw_d         = shift_q[0];
              addr_match_d = 1'b1;
              if (shift_q[0]) begin
                snap_sx_d = stick_x;
                snap_sy_d = stick_y;
                snap_ax_d = accel_x;
                snap_ay_d = accel_y;
                snap_az_d = accel_z;
                snap_z_d  = z;
                snap_c_d  = c;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d   = RD_BYTE;
              shift_d   = rd_data;
              sda_oe_d  = ~rd_data[7];
              bit_cnt_d = 4'd1;
            end else begin
              state_d      = WR_BYTE;
              sda_oe_d     = 1'b0;
              bit_cnt_d    = 4'd0;
              first_byte_d = 1'b1;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            // Byte is complete: acknowledge and commit it in one step
            state_d  = WR_ACK;
            sda_oe_d = 1'b1;
            if (first_byte_q) begin
              reg_ptr_d    = shift_q;
              first_byte_d = 1'b0;
            end else begin
              if (reg_ptr_q == 8'hF0 && shift_q == 8'h55) begin
                init_done_d = 1'b1;
              end
              reg_ptr_d = reg_ptr_q + 8'd1;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            state_d   = WR_BYTE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end

        RD_BYTE: begin
          // bit_cnt counts bits already placed on the wire
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = RD_ACK;
              sda_oe_d  = 1'b0;
              reg_ptr_d = reg_ptr_q + 8'd1;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        RD_ACK: begin
          // A NACK leaves at the rising edge; any later fall follows an ACK
          if (scl_rise && sda_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
          end else if (scl_fall) begin
            state_d   = RD_BYTE;
            shift_d   = rd_data;
            sda_oe_d  = ~rd_data[7];
            bit_cnt_d = 4'd1;
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      rw_q         <= 1'b0;
      first_byte_q <= 1'b0;
      addr_match_q <= 1'b0;
      sda_oe_q     <= 1'b0;
      init_done_q  <= 1'b0;
      reg_ptr_q    <= 8'h00;
      txn_done_q   <= 1'b0;
      snap_sx_q    <= 8'h00;
      snap_sy_q    <= 8'h00;
      snap_ax_q    <= 10'h000;
      snap_ay_q    <= 10'h000;
      snap_az_q    <= 10'h000;
      snap_z_q     <= 1'b0;
      snap_c_q     <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      first_byte_q <= first_byte_d;
      addr_match_q <= addr_match_d;
      sda_oe_q     <= sda_oe_d;
      init_done_q  <= init_done_d;
      reg_ptr_q    <= reg_ptr_d;
      txn_done_q   <= txn_done_d;
      snap_sx_q    <= snap_sx_d;
      snap_sy_q    <= snap_sy_d;
      snap_ax_q    <= snap_ax_d;
      snap_ay_q    <= snap_ay_d;
      snap_az_q    <= snap_az_d;
      snap_z_q     <= snap_z_d;
      snap_c_q     <= snap_c_d;
    end
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign init_done = init_done_q;
  assign reg_ptr   = reg_ptr_q;
  assign txn_done  = txn_done_q;

endmodule

// File: tb/tb_nunchuck_responder.sv
// ---------------------------------------------------------------------------
// tb_nunchuck_responder
//
// Bench acting as the I2C master for nunchuck_responder. A transaction-level
// model (init flag, register pointer, report snapshot) predicts ACKs, read
// bytes, the pointer and the txn_done count; a compare process checks the
// idle-bus outputs against that model every cycle between transactions.
// ---------------------------------------------------------------------------
module tb_nunchuck_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_low;
  wire        sda;
  logic [7:0] stick_x, stick_y;
  logic [9:0] accel_x, accel_y, accel_z;
  logic       z, c;
  logic       init_done;
  logic [7:0] reg_ptr;
  logic       txn_done;

  int n_cmp = 0;
  int n_bad = 0;
  int txn_cnt = 0;
  int exp_txn = 0;

  bit         m_init;
  logic [7:0] m_ptr;
  logic [7:0] snap [6];
  logic [7:0] rd_buf [8];
  bit         check_en = 1'b0;

  always #5 clk = ~clk;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup(sda);

  nunchuck_responder #(.DEV_ADDR(7'h52), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda(sda),
    .stick_x(stick_x), .stick_y(stick_y),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .z(z), .c(c),
    .init_done(init_done), .reg_ptr(reg_ptr), .txn_done(txn_done)
  );

  // Count completed transactions as reported by the DUT
  always @(posedge clk) begin
    if (txn_done === 1'b1) txn_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // Idle-bus compare process against the model
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("idle_init_done", {31'd0, init_done}, {31'd0, m_init});
      checkOutput("idle_reg_ptr", {24'd0, reg_ptr}, {24'd0, m_ptr});
      checkOutput("idle_sda_released", {31'd0, sda}, 32'd1);
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus();
    stick_x = 8'($urandom);
    stick_y = 8'($urandom);
    accel_x = 10'($urandom);
    accel_y = 10'($urandom);
    accel_z = 10'($urandom);
    z       = 1'($urandom);
    c       = 1'($urandom);
  endtask

  // Report as the nunchuck defines it, computed from the current ports
  task automatic capture_snapshot();
    int ax, ay, az;
    ax = int'(accel_x);
    ay = int'(accel_y);
    az = int'(accel_z);
    snap[0] = stick_x;
    snap[1] = stick_y;
    snap[2] = 8'(ax / 4);
    snap[3] = 8'(ay / 4);
    snap[4] = 8'(az / 4);
    snap[5] = 8'((az % 4) * 64 + (ay % 4) * 16 + (ax % 4) * 4 +
                 (c ? 0 : 2) + (z ? 0 : 1));
  endtask

  function automatic logic [7:0] model_rd();
    if (m_init && m_ptr < 8'd6) return snap[m_ptr[2:0]];
    return 8'hFF;
  endfunction

  task automatic i2c_start();
    sda_low = 1'b0; wait_clks(8);
    scl_m   = 1'b1; wait_clks(8);
    sda_low = 1'b1; wait_clks(8);
    scl_m   = 1'b0; wait_clks(8);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; wait_clks(8);
    scl_m   = 1'b1; wait_clks(8);
    sda_low = 1'b0; wait_clks(8);
  endtask

  task automatic send_bit(input logic b, output logic r);
    sda_low = ~b; wait_clks(8);
    scl_m   = 1'b1; wait_clks(8);
    r       = sda; wait_clks(8);
    scl_m   = 1'b0; wait_clks(8);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(d[i], r);
    send_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
    end
    send_bit(nack, r);
    if (nack) checkOutput("rd_ack_slot_release", {31'd0, r}, 32'd1);
  endtask

  task automatic idle_check();
    wait_clks(2);
    check_en = 1'b1;
    wait_clks(6);
    check_en = 1'b0;
    checkOutput("txn_count", txn_cnt, exp_txn);
  endtask

  // Write transaction: first byte is the pointer, the rest are data
  task automatic do_write(input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2);
    logic ack;
    logic [7:0] b;
    i2c_start();
    write_byte(8'hA4, ack);
    checkOutput("wr_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      write_byte(b, ack);
      checkOutput("wr_data_ack", {31'd0, ack}, 32'd1);
      if (i == 0) m_ptr = b;
      else begin
        if (m_ptr == 8'hF0 && b == 8'h55) m_init = 1'b1;
        m_ptr = m_ptr + 8'd1;
      end
    end
    i2c_stop();
    exp_txn++;
    idle_check();
  endtask

  // Read burst of n bytes, last one NACKed; optionally disturb the inputs
  task automatic do_read(input int n, input bit disturb);
    logic ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA5, ack);
    checkOutput("rd_addr_ack", {31'd0, ack}, 32'd1);
    capture_snapshot();
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      rd_buf[i] = d;
      checkOutput("rd_data", {24'd0, d}, {24'd0, model_rd()});
      m_ptr = m_ptr + 8'd1;
      if (disturb) applyStimulus();
    end
    for (int i = 0; i < 6; i++) begin
      wait_clks(1);
      checkOutput("nack_hold_release", {31'd0, sda}, 32'd1);
    end
    i2c_stop();
    exp_txn++;
    idle_check();
  endtask

  task automatic do_bad_addr(input logic [7:0] a);
    logic ack;
    i2c_start();
    write_byte(a, ack);
    checkOutput("bad_addr_no_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    idle_check();
  endtask

  task automatic set_fixed_inputs();
    stick_x = 8'h80; stick_y = 8'h7F;
    accel_x = 10'h201; accel_y = 10'h1FE; accel_z = 10'h3FF;
    z = 1'b1; c = 1'b0;
  endtask

  initial begin
    logic ack, r;
    logic [7:0] exp_fixed [6];
    exp_fixed[0] = 8'h80; exp_fixed[1] = 8'h7F; exp_fixed[2] = 8'h80;
    exp_fixed[3] = 8'h7F; exp_fixed[4] = 8'hFF; exp_fixed[5] = 8'hE6;

    rst = 1'b1; scl_m = 1'b1; sda_low = 1'b0;
    stick_x = '0; stick_y = '0; accel_x = '0; accel_y = '0; accel_z = '0;
    z = 1'b0; c = 1'b0;
    m_init = 1'b0; m_ptr = 8'h00;
    wait_clks(5);
    checkOutput("reset_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("reset_reg_ptr", {24'd0, reg_ptr}, 32'd0);
    checkOutput("reset_txn_done", {31'd0, txn_done}, 32'd0);
    checkOutput("reset_sda", {31'd0, sda}, 32'd1);
    rst = 1'b0;
    wait_clks(5);

    // Pre-init reads return 0xFF
    applyStimulus();
    do_write(1, 8'h00, 8'h00, 8'h00);
    do_read(6, 1'b0);
    for (int i = 0; i < 6; i++) checkOutput("preinit_ff", {24'd0, rd_buf[i]}, 32'hFF);
    checkOutput("preinit_ptr", {24'd0, reg_ptr}, 32'h06);

    // Init sequence
    do_write(2, 8'hF0, 8'h55, 8'h00);
    checkOutput("init_done_lit", {31'd0, init_done}, 32'd1);
    checkOutput("init_ptr_lit", {24'd0, reg_ptr}, 32'hF1);
    checkOutput("init_txn_lit", txn_cnt, 32'd3);

    // Fixed report with inputs disturbed mid-burst
    set_fixed_inputs();
    do_write(1, 8'h00, 8'h00, 8'h00);
    do_read(6, 1'b1);
    for (int i = 0; i < 6; i++)
      checkOutput("fixed_report_lit", {24'd0, rd_buf[i]}, {24'd0, exp_fixed[i]});

    // Wrong address and general call
    do_bad_addr(8'hA6);
    do_bad_addr(8'h00);

    // Read from pointer 4, ACK then NACK
    set_fixed_inputs();
    do_write(1, 8'h04, 8'h00, 8'h00);
    do_read(2, 1'b0);
    checkOutput("ptr4_b0_lit", {24'd0, rd_buf[0]}, 32'hFF);
    checkOutput("ptr4_b1_lit", {24'd0, rd_buf[1]}, 32'hE6);
    checkOutput("ptr4_ptr_lit", {24'd0, reg_ptr}, 32'h06);

    // Repeated START mid data byte, then STOP right after address ACK
    i2c_start();
    write_byte(8'hA4, ack);
    checkOutput("sr_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h10, ack);
    checkOutput("sr_ptr_ack", {31'd0, ack}, 32'd1);
    m_ptr = 8'h10;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), r);
    i2c_start();
    write_byte(8'hA4, ack);
    checkOutput("sr_readdr_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    exp_txn++;
    idle_check();
    checkOutput("sr_ptr_lit", {24'd0, reg_ptr}, 32'h10);

    // Pointer wrap
    do_write(3, 8'hFE, 8'h11, 8'h22);
    checkOutput("wrap_ptr_lit", {24'd0, reg_ptr}, 32'h00);

    // Randomized traffic
    for (int it = 0; it < 20; it++) begin
      applyStimulus();
      if ($urandom_range(0, 1) == 0) begin
        do_write($urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom),
                 ($urandom_range(0, 1) == 0) ? 8'h55 : 8'($urandom),
                 8'($urandom));
      end else begin
        if ($urandom_range(0, 2) != 0)
          do_write(1, ($urandom_range(0, 4) == 0) ? 8'hFE : 8'($urandom_range(0, 7)),
                   8'h00, 8'h00);
        do_read($urandom_range(1, 4), 1'($urandom));
      end
    end

    // Reset while a read drives a 0 bit
    set_fixed_inputs();
    stick_x = 8'h00;
    do_write(1, 8'h00, 8'h00, 8'h00);
    i2c_start();
    write_byte(8'hA5, ack);
    checkOutput("rst_rd_addr_ack", {31'd0, ack}, 32'd1);
    sda_low = 1'b0; wait_clks(8);
    scl_m = 1'b1; wait_clks(4);
    checkOutput("rst_rd_drive_low", {31'd0, sda}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_sda_release", {31'd0, sda}, 32'd1);
    checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("rst_reg_ptr", {24'd0, reg_ptr}, 32'd0);
    wait_clks(4);
    rst = 1'b0;
    m_init = 1'b0; m_ptr = 8'h00;
    wait_clks(4);
    scl_m = 1'b0; wait_clks(8);
    i2c_stop();
    idle_check();
    do_write(0, 8'h00, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
